// File: rtl/rpn_pkg.sv
// rpn_pkg -- shared definitions for the RPN stack controller.
//   opcode_e : token opcode encoding carried in tok_data[1:0]
//   state_e  : controller FSM states (DUP states only exist when
//              RPN_CONTROLLER_DUP_EN is defined)
//   RPN_DATA_WIDTH / RPN_STACK_DEPTH : default operand width and stack capacity
package rpn_pkg;

    localparam int RPN_DATA_WIDTH  = 4;
    localparam int RPN_STACK_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DUP = 2'd3
    } opcode_e;

    typedef enum logic [3:0] {
        IDLE,
        PUSH_NUM,
        POP_B,
        POP_A,
        EXEC,
        PUSH_RES
`ifdef RPN_CONTROLLER_DUP_EN
        ,
        PEAK,
        PEAK_WAIT,
        PUSH_DUP
`endif
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu -- combinational arithmetic for the RPN controller.
//   a, b   : operands (result is a <op> b)
//   op     : ADD / SUB / MUL; any other opcode yields 0 with no carry
//   result : truncated to WIDTH bits
//   carry  : ADD carry out, SUB borrow, or MUL discarded high bits non-zero
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = RPN_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_e          op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;

    assign sum  = {1'b0, a} + {1'b0, b};
    // MSB of the extended difference is set exactly when a < b (borrow).
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            OP_MUL: begin
                result = prod[WIDTH-1:0];
                carry  = |prod[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rpn_controller.sv
// rpn_controller -- evaluates an RPN token stream against an external stack.
//   clk, rst           : clock, asynchronous active-high reset
//   tok_valid/ready    : token handshake; tok_is_op selects operator vs number,
//                        tok_data holds the number or the opcode in [1:0]
//   stk_push/pop/peak  : one-cycle stack command strobes, stk_dataIn is push data,
//                        stk_dataOut returns data the cycle after pop/peak
//   top, depth         : last pushed value, current stack occupancy
//   flag_carry         : carry/borrow/overflow of the last arithmetic result
//   err_underflow/overflow/illegal : single-cycle error pulses
// Define RPN_CONTROLLER_DUP_EN to execute opcode 3 as DUP; otherwise it is
// reported as illegal and stk_peak stays 0.
module rpn_controller
    import rpn_pkg::*;
#(
    parameter int DATA_WIDTH  = RPN_DATA_WIDTH,
    parameter int STACK_DEPTH = RPN_STACK_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tok_valid,
    output logic                               tok_ready,
    input  logic                               tok_is_op,
    input  logic [DATA_WIDTH-1:0]              tok_data,
    output logic                               stk_push,
    output logic                               stk_pop,
    output logic                               stk_peak,
    output logic [DATA_WIDTH-1:0]              stk_dataIn,
    input  logic [DATA_WIDTH-1:0]              stk_dataOut,
    output logic [DATA_WIDTH-1:0]              top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               flag_carry,
    output logic                               err_underflow,
    output logic                               err_overflow,
    output logic                               err_illegal
);

    localparam int              DW   = $clog2(STACK_DEPTH+1);
    localparam logic [DW-1:0]   FULL = DW'(STACK_DEPTH);
    localparam logic [DW-1:0]   ONE  = DW'(1);

    state_e                  state_q, state_d;
    opcode_e                 op_q, op_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   val_q, val_d;   // value for the next push
    logic [DATA_WIDTH-1:0]   top_q, top_d;
    logic [DW-1:0]           depth_q, depth_d;
    logic                    carry_q, carry_d;
    logic                    uf_q, uf_d, ov_q, ov_d, il_q, il_d;

    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_carry;
    logic                    accept;
    opcode_e                 tok_op;

    assign tok_ready     = (state_q == IDLE) && !rst;
    assign accept        = tok_valid && tok_ready;
    assign tok_op        = opcode_e'(tok_data[1:0]);

    assign stk_dataIn    = val_q;
    assign top           = top_q;
    assign depth         = depth_q;
    assign flag_carry    = carry_q;
    assign err_underflow = uf_q;
    assign err_overflow  = ov_q;
    assign err_illegal   = il_q;

    // Operand A is consumed straight off stk_dataOut during EXEC.
    rpn_alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .a      (stk_dataOut),
        .b      (b_q),
        .op     (op_q),
        .result (alu_res),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        val_d    = val_q;
        top_d    = top_q;
        depth_d  = depth_q;
        carry_d  = carry_q;
        uf_d     = 1'b0;
        ov_d     = 1'b0;
        il_d     = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_peak = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!tok_is_op) begin
                        if (depth_q == FULL) begin
                            ov_d = 1'b1;
                        end else begin
                            val_d   = tok_data;
                            state_d = PUSH_NUM;
                        end
                    end else begin
                        op_d = tok_op;
                        if (tok_op == OP_DUP) begin
`ifdef RPN_CONTROLLER_DUP_EN
                            if (depth_q == '0)        uf_d    = 1'b1;
                            else if (depth_q == FULL) ov_d    = 1'b1;
                            else                      state_d = PEAK;
`else
                            il_d = 1'b1;
`endif
                        end else if (int'(depth_q) < 2) begin
                            uf_d = 1'b1;
                        end else begin
                            state_d = POP_B;
                        end
                    end
                end
            end
            PUSH_NUM, PUSH_RES: begin
                stk_push = 1'b1;
                depth_d  = depth_q + ONE;
                top_d    = val_q;
                state_d  = IDLE;
            end
            POP_B: begin
                stk_pop = 1'b1;
                depth_d = depth_q - ONE;
                state_d = POP_A;
            end
            POP_A: begin
                // Data from the POP_B strobe is valid now: that is operand B.
                stk_pop = 1'b1;
                depth_d = depth_q - ONE;
                b_d     = stk_dataOut;
                state_d = EXEC;
            end
            EXEC: begin
                val_d   = alu_res;
                carry_d = alu_carry;
                state_d = PUSH_RES;
            end
`ifdef RPN_CONTROLLER_DUP_EN
            PEAK: begin
                stk_peak = 1'b1;
                state_d  = PEAK_WAIT;
            end
            PEAK_WAIT: begin
                val_d   = stk_dataOut;
                state_d = PUSH_DUP;
            end
            PUSH_DUP: begin
                stk_push = 1'b1;
                depth_d  = depth_q + ONE;
                top_d    = val_q;
                state_d  = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            b_q     <= '0;
            val_q   <= '0;
            top_q   <= '0;
            depth_q <= '0;
            carry_q <= 1'b0;
            uf_q    <= 1'b0;
            ov_q    <= 1'b0;
            il_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            val_q   <= val_d;
            top_q   <= top_d;
            depth_q <= depth_d;
            carry_q <= carry_d;
            uf_q    <= uf_d;
            ov_q    <= ov_d;
            il_q    <= il_d;
        end
    end

endmodule

// File: tb/tb_rpn_controller.sv
// tb_rpn_controller -- directed and random token streams against a queue-based
// RPN reference model, with a behavioural stack attached to the DUT.
module tb_rpn_controller;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       tok_valid;
    logic       tok_ready;
    logic       tok_is_op;
    logic [3:0] tok_data;
    logic       stk_push, stk_pop, stk_peak;
    logic [3:0] stk_dataIn;
    logic [3:0] stk_dataOut;
    logic [3:0] top;
    logic [2:0] depth;
    logic       flag_carry;
    logic       err_underflow, err_overflow, err_illegal;

    rpn_controller #(.DATA_WIDTH(4), .STACK_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .tok_valid     (tok_valid),
        .tok_ready     (tok_ready),
        .tok_is_op     (tok_is_op),
        .tok_data      (tok_data),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_peak      (stk_peak),
        .stk_dataIn    (stk_dataIn),
        .stk_dataOut   (stk_dataOut),
        .top           (top),
        .depth         (depth),
        .flag_carry    (flag_carry),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_illegal   (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: read data appears the cycle after pop/peak.
    logic [3:0] mem [0:7];
    int         sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp          <= 0;
            stk_dataOut <= 4'd0;
        end else begin
            if (stk_push && sp < 8) begin
                mem[sp] <= stk_dataIn;
                sp      <= sp + 1;
            end
            if (stk_pop && sp > 0) begin
                stk_dataOut <= mem[sp-1];
                sp          <= sp - 1;
            end
            if (stk_peak && sp > 0) stk_dataOut <= mem[sp-1];
        end
    end

    // Cumulative strobe / pulse counters, sampled on the pre-edge values.
    int c_push = 0, c_pop = 0, c_peak = 0, c_uf = 0, c_ov = 0, c_il = 0, c_multi = 0;
    always @(posedge clk) begin
        if (!rst) begin
            c_push <= c_push + int'(stk_push);
            c_pop  <= c_pop  + int'(stk_pop);
            c_peak <= c_peak + int'(stk_peak);
            c_uf   <= c_uf   + int'(err_underflow);
            c_ov   <= c_ov   + int'(err_overflow);
            c_il   <= c_il   + int'(err_illegal);
            if (int'(stk_push) + int'(stk_pop) + int'(stk_peak) > 1) c_multi <= c_multi + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_tok  = 0;

    // Reference model: the RPN stack as a queue of values.
    int ref_stk[$];
    int ref_top   = 0;
    int ref_carry = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (token %0d): observed %0d expected %0d", tag, n_tok, obs, exp);
    endtask

    task automatic model_clear();
        ref_stk.delete();
        ref_top   = 0;
        ref_carry = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        tok_valid = 1'b0;
        #1;
        check("rst_ready",   tok_ready, 0);
        check("rst_depth",   depth, 0);
        check("rst_top",     top, 0);
        check("rst_carry",   flag_carry, 0);
        check("rst_strobes", {stk_push, stk_pop, stk_peak}, 0);
        check("rst_errs",    {err_underflow, err_overflow, err_illegal}, 0);
        check("rst_dataIn",  stk_dataIn, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic is_op, input logic [3:0] d);
        int cyc, wt;
        int p_push, p_pop, p_peak, p_uf, p_ov, p_il;
        int e_push, e_pop, e_peak, e_uf, e_ov, e_il, e_lat;
        int av, bv, full, v;
        e_push = 0; e_pop = 0; e_peak = 0; e_uf = 0; e_ov = 0; e_il = 0; e_lat = 1;
        n_tok++;

        @(negedge clk);
        wt = 0;
        while (!tok_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        p_push = c_push; p_pop = c_pop; p_peak = c_peak;
        p_uf = c_uf; p_ov = c_ov; p_il = c_il;
        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = d;
        @(posedge clk);
        #1 tok_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!tok_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;

        if (!is_op) begin
            if (ref_stk.size() == DEPTH) e_ov = 1;
            else begin
                ref_stk.push_back(int'(d));
                ref_top = int'(d);
                e_push = 1;
                e_lat  = 2;
            end
        end else if (d[1:0] == 2'd3) begin
`ifdef RPN_CONTROLLER_DUP_EN
            if (ref_stk.size() == 0) e_uf = 1;
            else if (ref_stk.size() == DEPTH) e_ov = 1;
            else begin
                v = ref_stk[$];
                ref_stk.push_back(v);
                ref_top = v;
                e_peak = 1;
                e_push = 1;
                e_lat  = 4;
            end
`else
            e_il = 1;
`endif
        end else begin
            if (ref_stk.size() < 2) e_uf = 1;
            else begin
                bv = ref_stk.pop_back();
                av = ref_stk.pop_back();
                case (d[1:0])
                    2'd0:    full = av + bv;
                    2'd1:    full = av - bv;
                    default: full = av * bv;
                endcase
                ref_carry = (full < 0 || full > 15) ? 1 : 0;
                ref_stk.push_back(full & 15);
                ref_top = full & 15;
                e_pop  = 2;
                e_push = 1;
                e_lat  = 5;
            end
        end

        check("latency",   cyc, e_lat);
        check("depth",     depth, ref_stk.size());
        check("top",       top, ref_top);
        check("carry",     flag_carry, ref_carry);
        check("n_push",    c_push - p_push, e_push);
        check("n_pop",     c_pop - p_pop, e_pop);
        check("n_peak",    c_peak - p_peak, e_peak);
        check("underflow", c_uf - p_uf, e_uf);
        check("overflow",  c_ov - p_ov, e_ov);
        check("illegal",   c_il - p_il, e_il);
        check("stack_sp",  sp, ref_stk.size());
        if (sp > 0 && ref_stk.size() > 0) check("stack_val", mem[sp-1], ref_stk[$]);
    endtask

    initial begin
        rst       = 1'b1;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = 4'd0;

        // 3 5 + -> 8
        do_reset();
        send(0, 4'd3); send(0, 4'd5); send(1, 4'd0);
        check("add_top", top, 8);
        check("add_carry", flag_carry, 0);

        // 1 2 - -> 15 with borrow
        do_reset();
        send(0, 4'd1); send(0, 4'd2); send(1, 4'd1);
        check("sub_top", top, 15);
        check("sub_carry", flag_carry, 1);

        // 3 6 * -> 2 with discarded bits
        do_reset();
        send(0, 4'd3); send(0, 4'd6); send(1, 4'd2);
        check("mul_top", top, 2);
        check("mul_carry", flag_carry, 1);

        // underflow on empty, overflow on the fifth push
        do_reset();
        send(1, 4'd0);
        for (int i = 1; i <= 5; i++) send(0, 4'(i));
        check("full_depth", depth, 4);

        // DUP (or illegal opcode)
        do_reset();
        send(0, 4'd7); send(1, 4'd3);

        // reset while in POP_A
        do_reset();
        send(0, 4'd1); send(0, 4'd2);
        @(negedge clk);
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 4'd0;
        @(posedge clk);
        #1 tok_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("popa_pop", stk_pop, 1);
        rst = 1'b1;
        #1;
        check("midrst_strobes", {stk_push, stk_pop, stk_peak}, 0);
        check("midrst_depth", depth, 0);
        check("midrst_ready", tok_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_ready", tok_ready, 1);
        model_clear();
        @(posedge clk);
        #1;
        send(0, 4'd9);

        // random token stream
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 55) send(0, 4'($urandom_range(0, 15)));
            else send(1, 4'($urandom_range(0, 3)));
            if (i % 97 == 96) do_reset();
        end

        check("one_strobe", c_multi, 0);
`ifndef RPN_CONTROLLER_DUP_EN
        check("peak_never", c_peak, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
